main_memory_responder: RTL

Main-memory side of the cache/TLB CPU's memory port. It accepts single-word read and write requests on the `mem_access` / `mem_write` / `mem_a` / `mem_st_data` bus and performs them against an internal word-addressed RAM. After a fixed, parameterised latency it returns `mem_data` together with a one-cycle `mem_ready` pulse. It sits at the top level beside the CPU in place of the behavioural memory model, and it also checks that the initiator keeps the request stable while the access is pending.

---
 rtl/main_memory_responder_if.sv | 20 ++
 rtl/main_memory_responder.sv | 100 ++++++++++
 2 files changed

// File: rtl/main_memory_responder_if.sv
// Memory-port bus between the CPU (master) and the main-memory responder (slave).
// The initiator holds the request fields stable until mem_ready pulses.
interface main_memory_responder_if;
  logic        mem_access;
  logic        mem_write;
  logic [31:0] mem_a;
  logic [31:0] mem_st_data;
  logic [31:0] mem_data;
  logic        mem_ready;

  modport master (
    output mem_access, mem_write, mem_a, mem_st_data,
    input  mem_data, mem_ready
  );

  modport slave (
    input  mem_access, mem_write, mem_a, mem_st_data,
    output mem_data, mem_ready
  );
endinterface

// File: rtl/main_memory_responder.sv
// Word-addressed main memory behind the CPU memory port: fixed-latency single-word
// reads/writes with a one-cycle ready pulse and a sticky request-stability check.
module main_memory_responder #(
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 4
) (
  input  logic                    clk,
  input  logic                    clrn,
  main_memory_responder_if.slave  bus,
  output logic                    busy,
  output logic                    proto_err
);

  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic [1:0] {IDLE, WAIT, READY} state_t;

  state_t                state;
  logic [4:0]            count;
  logic [ADDR_BITS-1:0]  req_index;
  logic                  req_write;
  logic [31:0]           req_data;
  logic [31:0]           ram [DEPTH];

  logic [ADDR_BITS-1:0]  bus_index;
  logic                  req_changed;
  logic                  commit;
  logic [31:0]           unused_addr;

  // Byte-offset and upper address bits are deliberately ignored, so the word index wraps.
  assign unused_addr = bus.mem_a;
  assign bus_index   = bus.mem_a[ADDR_BITS+1:2];

  assign req_changed = !bus.mem_access
                     || (bus.mem_write != req_write)
                     || (bus_index != req_index)
                     || (bus.mem_write && (bus.mem_st_data != req_data));

  assign commit = (state == WAIT) && (count == 5'd0);

  // RAM has no reset so its contents survive clrn; a reset mid-access drops the write via state.
  always_ff @(posedge clk) begin
    if (commit && req_write) begin
      ram[req_index] <= req_data;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state         <= IDLE;
      count         <= 5'd0;
      req_index     <= '0;
      req_write     <= 1'b0;
      req_data      <= 32'd0;
      bus.mem_data  <= 32'd0;
      bus.mem_ready <= 1'b0;
      busy          <= 1'b0;
      proto_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.mem_ready <= 1'b0;
          if (bus.mem_access) begin
            req_index <= bus_index;
            req_write <= bus.mem_write;
            req_data  <= bus.mem_st_data;
            count     <= 5'(LATENCY - 1);
            busy      <= 1'b1;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (req_changed) begin
            proto_err <= 1'b1;
          end
          if (count != 5'd0) begin
            count <= count - 5'd1;
          end else begin
            if (!req_write) begin
              bus.mem_data <= ram[req_index];
            end
            bus.mem_ready <= 1'b1;
            state         <= READY;
          end
        end
        READY: begin
          bus.mem_ready <= 1'b0;
          busy          <= 1'b0;
          state         <= IDLE;
        end
        default: begin
          bus.mem_ready <= 1'b0;
          busy          <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule
